// File: rtl/riscv_mc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mc_controller_pkg
//  Description : Shared types and encodings for the multicycle RISC-V
//                controller: FSM state enum, opcodes, ALU operation codes
//                and datapath mux-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mc_controller_pkg;

    // Controller states. TRAP is only reachable when the illegal-opcode
    // trap is built in; otherwise its encoding is simply never entered.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU operation codes driven to the datapath
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Coarse ALU request from the FSM to the funct decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, independent of state
    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LW, OP_I: imm = IMM_I;
            OP_SW:       imm = IMM_S;
            OP_BEQ:      imm = IMM_B;
            OP_JAL:      imm = IMM_J;
            default:     imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mc_controller_if
//  Description : Instruction/status inputs and datapath control outputs of
//                the multicycle controller. The datapath side uses the
//                master modport, the controller uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       illegal;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, reg_write, imm_src, illegal
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, reg_write, imm_src, illegal
    );
endinterface
`default_nettype wire

// File: rtl/riscv_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_alu_decoder
//  Description : Combinational ALU operation decoder. Turns the FSM's coarse
//                ALU request plus the funct fields into an ALU control code.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_decoder
    import riscv_mc_controller_pkg::*;
(
    input  wire logic [1:0] alu_op,
    input  wire logic [2:0] funct3,
    input  wire logic       funct7b5,
    input  wire logic       op5,
    output logic [2:0]      alu_control
);

    // op5 separates R-type (1) from I-type (0); only R-type may subtract
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mc_controller
//  Description : Moore-style multicycle RISC-V control FSM (lw, sw, R-type,
//                I-type ALU, beq, jal). Memory handshakes stall on mem_ready.
//                Build option CTRL_ILLEGAL_TRAP_EN: unsupported opcodes enter
//                a TRAP state that raises a sticky illegal flag until reset;
//                without it they are skipped and illegal stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_controller
    import riscv_mc_controller_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    riscv_mc_controller_if.slave bus
);

    state_t     state;
    state_t     state_next;

    logic       ready_eff;
    logic [1:0] alu_op;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [2:0] alu_control;

    // While reset is held the handshake is masked so FETCH raises no enables
    assign ready_eff = bus.mem_ready & rst_n;

    // State register, asynchronously forced to FETCH by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        adr_src    = ADR_PC;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;

        case (state)
            ST_FETCH: begin
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = ready_eff;
                pc_write   = ready_eff;
                if (ready_eff) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Precompute branch/jump target PC_old + imm while decoding
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_R:         state_next = ST_EXECR;
                    OP_I:         state_next = ST_EXECI;
                    OP_BEQ:       state_next = ST_BEQ;
                    OP_JAL:       state_next = ST_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_next = ST_TRAP;
`else
                    default:      state_next = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (bus.op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                adr_src = ADR_ALUOUT;
                if (ready_eff) begin
                    state_next = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWRITE: begin
                // Strobe stays up for the whole access, not just the last cycle
                adr_src   = ADR_ALUOUT;
                mem_write = 1'b1;
                if (ready_eff) begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_OP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_OP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQ: begin
                // ALU out still holds the target computed in DECODE
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_OP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = bus.zero;
                state_next = ST_FETCH;
            end
            ST_JAL: begin
                // Load PC with target while computing link value PC_old + 4
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = ST_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
`endif
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    riscv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_control)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag, raised on the edge that enters TRAP so it is visible in TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_next == ST_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.pc_write    = pc_write;
    assign bus.adr_src     = adr_src;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;
    assign bus.reg_write   = reg_write;
    assign bus.imm_src     = imm_decode(bus.op);

endmodule
`default_nettype wire
